coeff_seq: RTL and testbench
============================

COEFF_SEQ -- requirements
Module: coeff_seq

Interface
REQ-001 Parameter ADDR_WIDTH, 6, width of coefficient index/ROM address.
REQ-002 Parameter DATA_WIDTH, 32, coefficient width (IEEE-754 single).
REQ-003 Parameter NUM_COEFF, 33, ROM depth (entries 1/0! .. 1/32!).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-high (asserted = 1), per codebase port naming.
REQ-006 start  in  1  one-cycle request to begin a coefficient sequence.
REQ-007 num_terms  in  ADDR_WIDTH+1  number of coefficients to stream, sampled with start.
REQ-008 descend  in  1  sampled with start; 1 = index num_terms-1 down to 0 (Horner), 0 = 0 up to num_terms-1.
REQ-009 rom_rd  out  1  ROM read strobe.
REQ-010 rom_addr  out  ADDR_WIDTH  ROM read address.
REQ-011 rom_data  in  DATA_WIDTH  ROM registered output, valid the cycle after the ROM samples rom_rd; held while rom_rd low.
REQ-012 coeff_valid  out  1  output beat valid.
REQ-013 coeff_ready  in  1  downstream accept.
REQ-014 coeff_data  out  DATA_WIDTH  coefficient value.
REQ-015 coeff_idx  out  ADDR_WIDTH  ROM index of coeff_data.
REQ-016 coeff_last  out  1  final beat of sequence.
REQ-017 busy  out  1  sequence in progress.
REQ-018 done  out  1  one-cycle pulse, sequence complete.
REQ-019 err  out  1  one-cycle pulse, invalid num_terms.

Function
REQ-020 FSM states IDLE, FETCH, DRAIN, FIN; IDLE->FETCH on start with 1<=num_terms; FETCH->DRAIN after last read issued; DRAIN->FIN when last beat handshaked; FIN->IDLE next cycle with done=1.
REQ-021 start while busy=1 is ignored; no effect on the running sequence.
REQ-022 num_terms=0 with start: no reads, no beats, err=1 and done=1 in the following cycle, stays IDLE.
REQ-023 num_terms>NUM_COEFF: clamped to NUM_COEFF, err=1 one cycle after start, sequence proceeds.
REQ-024 rom_rd, rom_addr are registered; rom_data captured the cycle after the ROM edge that sampled rom_rd (2-stage read pipeline).
REQ-025 Output buffer: 4-entry FIFO of {data, idx, last}; read issued only if FIFO occupancy + reads in flight < 4; no beat ever dropped or duplicated.
REQ-026 With coeff_ready held 1: first coeff_valid exactly 3 cycles after the start edge, then one beat per cycle.
REQ-027 Beat transfers on coeff_valid & coeff_ready; coeff_data/idx/last stable while coeff_valid=1 and coeff_ready=0.
REQ-028 coeff_last=1 only on the num_terms-th beat; coeff_idx=0 on last beat when descend=1, num_terms-1 when descend=0.
REQ-029 Index counter counts without wrap; never addresses beyond NUM_COEFF-1 or below 0.
REQ-030 busy=1 from cycle after accepted start through FIN; 0 in IDLE.

Reset
REQ-031 Reset sampled on rising clk while rst_n=1; overrides all activity including mid-sequence; FIFO emptied, in-flight reads discarded.
REQ-032 Reset values: state IDLE, rom_rd=0, rom_addr=0, coeff_valid=0, coeff_data=0, coeff_idx=0, coeff_last=0, busy=0, done=0, err=0.
REQ-033 First start accepted the cycle after rst_n returns to 0.

Verification
REQ-034 start, num_terms=3, descend=0, ready=1 -> beats 3f800000, 3f800000, 3f000000, idx 0,1,2, last on third, done pulse after.
REQ-035 start, num_terms=4, descend=1 -> beats 3e2aaaab, 3f000000, 3f800000, 3f800000, idx 3..0, last with idx 0.
REQ-036 num_terms=8, ready toggled low 5 cycles mid-stream -> rom_rd stalls at FIFO limit, all 8 beats in order, data stable during stall.
REQ-037 num_terms=0 -> err=1, done=1, no rom_rd, no coeff_valid; num_terms=40 -> err=1, 33 beats, last data 04a1a697 (ascending).
REQ-038 rst_n=1 during beat 5 of 16 -> all outputs at reset values next cycle; subsequent start num_terms=2 yields 3f800000, 3f800000 only.

Source files
------------

// File: rtl/coeff_seq.sv
// Streams 1/k! coefficients from an external registered ROM through a
// 4-entry output FIFO, ascending or descending, with valid/ready backpressure.
module coeff_seq #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_COEFF  = 33
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_terms,
    input  logic                  descend,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  coeff_valid,
    input  logic                  coeff_ready,
    output logic [DATA_WIDTH-1:0] coeff_data,
    output logic [ADDR_WIDTH-1:0] coeff_idx,
    output logic                  coeff_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] MAXN = CW'(NUM_COEFF);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t state;

    logic [CW-1:0] n_clamp;
    logic [CW-1:0] rem;
    logic          dir;
    logic          rd_last;

    logic                  v1;
    logic [ADDR_WIDTH-1:0] v1_idx;
    logic                  v1_last;
    logic                  cap_v;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [ADDR_WIDTH-1:0] cap_idx;
    logic                  cap_last;

    logic [DATA_WIDTH-1:0] f_data [4];
    logic [ADDR_WIDTH-1:0] f_idx  [4];
    logic                  f_last [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            f_cnt;

    logic       pop;
    logic [3:0] total;
    logic       can_issue;

    assign n_clamp     = (num_terms > MAXN) ? MAXN : num_terms;
    assign coeff_valid = (f_cnt != 3'd0);
    assign coeff_data  = f_data[rd_ptr];
    assign coeff_idx   = f_idx[rd_ptr];
    assign coeff_last  = f_last[rd_ptr];
    assign pop         = coeff_valid & coeff_ready;

    // Slots claimed = FIFO entries + reads anywhere in the ROM pipeline;
    // a beat leaving this cycle frees its slot for a new read.
    assign total     = 4'(f_cnt) + 4'(rom_rd) + 4'(v1) + 4'(cap_v);
    assign can_issue = (total - 4'(pop)) < 4'd4;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            rom_rd   <= 1'b0;
            rom_addr <= '0;
            rd_last  <= 1'b0;
            rem      <= '0;
            dir      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rom_rd <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_terms == '0) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err      <= (num_terms > MAXN);
                            state    <= FETCH;
                            busy     <= 1'b1;
                            rom_rd   <= 1'b1;
                            rom_addr <= descend ?
                                        ADDR_WIDTH'(n_clamp - CW'(1)) : '0;
                            rd_last  <= (n_clamp == CW'(1));
                            rem      <= n_clamp - CW'(1);
                            dir      <= descend;
                        end
                    end
                end
                FETCH: begin
                    if (rem == '0) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        rom_rd   <= 1'b1;
                        rom_addr <= dir ? rom_addr - 1'b1 : rom_addr + 1'b1;
                        rd_last  <= (rem == CW'(1));
                        rem      <= rem - CW'(1);
                    end
                end
                DRAIN: begin
                    if (pop && coeff_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            v1       <= 1'b0;
            v1_idx   <= '0;
            v1_last  <= 1'b0;
            cap_v    <= 1'b0;
            cap_data <= '0;
            cap_idx  <= '0;
            cap_last <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            f_cnt    <= '0;
            for (int i = 0; i < 4; i++) begin
                f_data[i] <= '0;
                f_idx[i]  <= '0;
                f_last[i] <= 1'b0;
            end
        end else begin
            v1      <= rom_rd;
            v1_idx  <= rom_addr;
            v1_last <= rd_last;
            cap_v   <= v1;
            if (v1) begin
                cap_data <= rom_data;
                cap_idx  <= v1_idx;
                cap_last <= v1_last;
            end
            if (cap_v) begin
                f_data[wr_ptr] <= cap_data;
                f_idx[wr_ptr]  <= cap_idx;
                f_last[wr_ptr] <= cap_last;
                wr_ptr         <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            f_cnt <= f_cnt + 3'(cap_v) - 3'(pop);
        end
    end

endmodule

// File: tb/tb_coeff_seq.sv
// Scoreboard bench for coeff_seq with a registered 1/k! ROM model.
module tb_coeff_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  num_terms;
    logic        descend;
    logic        rom_rd;
    logic [5:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [31:0] coeff_data;
    logic [5:0]  coeff_idx;
    logic        coeff_last;
    logic        busy;
    logic        done;
    logic        err;

    coeff_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
        .descend(descend), .rom_rd(rom_rd), .rom_addr(rom_addr),
        .rom_data(rom_data), .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready), .coeff_data(coeff_data),
        .coeff_idx(coeff_idx), .coeff_last(coeff_last), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [33];
    initial begin
        rom = '{32'h3f800000, 32'h3f800000, 32'h3f000000, 32'h3e2aaaab,
                32'h3d2aaaab, 32'h3c088889, 32'h3ab60b61, 32'h39500d01,
                32'h37d00d01, 32'h3638ef1d, 32'h3493f27e, 32'h32d7322b,
                32'h310f76c7, 32'h2f309231, 32'h2d49cba5, 32'h2b573f9f,
                32'h29573f9f, 32'h274a963c, 32'h253413c3, 32'h2317a4da,
                32'h20f2a15d, 32'h1eb8dc78, 32'h1c8671cb, 32'h1a3b0da1,
                32'h17f96781, 32'h159f9e67, 32'h13447430, 32'h10e8d58e,
                32'h0e850c51, 32'h0c12cfcc, 32'h099c9963, 32'h0721a697,
                32'h04a1a697};
    end

    always @(posedge clk) begin
        if (rom_rd && rom_addr < 6'd33) rom_data <= rom[rom_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [38:0] sb [$];
    int beats = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int max_out = 0;
    logic        hold_v = 1'b0;
    logic [38:0] hold_val;
    logic [31:0] last_data;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: counts strobes, checks stall stability, pops scoreboard.
    always @(negedge clk) begin
        logic [38:0] exp;
        if (rom_rd) rd_cnt++;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (hold_v) begin
            check("stall_hold", {24'd0, coeff_valid, coeff_data, coeff_idx,
                  coeff_last}, {24'd0, 1'b1, hold_val});
        end
        if (coeff_valid && coeff_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %0h idx %0d with empty scoreboard",
                         coeff_data, coeff_idx);
            end else begin
                exp = sb.pop_front();
                check("beat", {25'd0, coeff_data, coeff_idx, coeff_last},
                      {25'd0, exp});
            end
            beats++;
            last_data = coeff_data;
        end
        hold_v   = coeff_valid && !coeff_ready;
        hold_val = {coeff_data, coeff_idx, coeff_last};
        if (rd_cnt - beats > max_out) max_out = rd_cnt - beats;
    end

    task automatic issue(int n, bit desc);
        int m;
        int idx;
        m = (n > 33) ? 33 : n;
        for (int i = 0; i < m; i++) begin
            idx = desc ? m - 1 - i : i;
            sb.push_back({rom[idx], 6'(idx), (i == m - 1)});
        end
        start     = 1'b1;
        num_terms = 7'(n);
        descend   = desc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(string nm);
        int i;
        for (i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !busy && !coeff_valid) break;
        end
        check({nm, "_complete"}, 64'(i < 400), 64'd1);
    endtask

    task automatic check_reset_vals(string nm);
        check({nm, "_outs"},
              {22'd0, rom_rd, rom_addr, coeff_valid, coeff_data, coeff_idx,
               coeff_last, busy, done, err}, 64'd0);
    endtask

    int d0;
    int e0;
    int r0;
    int b0;
    int k;

    initial begin
        rst_n       = 1'b1;
        start       = 1'b0;
        num_terms   = '0;
        descend     = 1'b0;
        coeff_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b0;

        // 3 ascending, start right after reset release, latency check
        d0 = done_cnt;
        e0 = err_cnt;
        issue(3, 1'b0);
        check("busy_after_start", 64'(busy), 64'd1);
        @(posedge clk);
        @(posedge clk);
        #1 check("valid_at_2", 64'(coeff_valid), 64'd0);
        @(posedge clk);
        #1 check("valid_at_3", 64'(coeff_valid), 64'd1);
        wait_idle("asc3");
        check("asc3_done", 64'(done_cnt - d0), 64'd1);
        check("asc3_err", 64'(err_cnt - e0), 64'd0);

        // 4 descending, with a start while busy that must be ignored
        d0 = done_cnt;
        issue(4, 1'b1);
        @(posedge clk);
        #1 start = 1'b1;
        num_terms = 7'd1;
        descend = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("desc4");
        check("desc4_done", 64'(done_cnt - d0), 64'd1);

        // 8 ascending with ready low 5 cycles
        max_out = 0;
        b0 = beats;
        issue(8, 1'b0);
        for (k = 0; k < 50 && beats < b0 + 2; k++) begin
            @(posedge clk);
            #1;
        end
        coeff_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 coeff_ready = 1'b1;
        wait_idle("stall8");
        check("stall8_beats", 64'(beats - b0), 64'd8);
        check("fifo_limit", 64'(max_out), 64'd4);

        // num_terms = 0
        d0 = done_cnt;
        e0 = err_cnt;
        r0 = rd_cnt;
        b0 = beats;
        issue(0, 1'b0);
        check("zero_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("zero_err", 64'(err_cnt - e0), 64'd1);
        check("zero_done", 64'(done_cnt - d0), 64'd1);
        check("zero_reads", 64'(rd_cnt - r0), 64'd0);
        check("zero_beats", 64'(beats - b0), 64'd0);

        // num_terms = 40 clamps to 33
        e0 = err_cnt;
        b0 = beats;
        issue(40, 1'b0);
        wait_idle("clamp40");
        check("clamp_err", 64'(err_cnt - e0), 64'd1);
        check("clamp_beats", 64'(beats - b0), 64'd33);
        check("clamp_last", 64'(last_data), 64'h04a1a697);

        // reset during beat 5 of 16
        b0 = beats;
        issue(16, 1'b0);
        for (k = 0; k < 50 && beats < b0 + 4; k++) begin
            @(posedge clk);
            #1;
        end
        check("beat5_present", 64'(coeff_valid), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_reset_vals("midreset");
        sb.delete();
        rd_cnt = beats;
        rst_n = 1'b0;
        b0 = beats;
        issue(2, 1'b0);
        wait_idle("post_reset2");
        check("post_reset_beats", 64'(beats - b0), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
